// File: rtl/sterownik_skanowania.sv
// Scan sequencer for the 4-digit HH:MM multiplexed display: digit select,
// anti-ghosting blank window, blinking separator dot and edit-mode blanking.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_OFF  | display dark, slot/blink counters and faza held cleared
// ST_BLANK| first GHOST_CYC clocks of a digit slot, anode forced off
// ST_SHOW | rest of the slot, digit lit unless edit blinking hides it
module sterownik_skanowania #(
    parameter int SCAN_DIV  = 50000,
    parameter int GHOST_CYC = 1000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] tryb_ustaw,
    input  logic       sync_sek,
    output logic [1:0] odswiezanie_o,
    output logic       wygas_o,
    output logic       kropka_o
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] GHOST_LAST = SW'(GHOST_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } stan_t;

    stan_t         stan, stan_nx;
    logic [SW-1:0] slot_cnt, slot_cnt_nx;
    logic [BW-1:0] blink_cnt, blink_cnt_nx;
    logic          faza, faza_nx;
    logic [1:0]    sel_nx;
    logic          edit_blank;
    logic          wygas_nx;
    logic          kropka_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stan          <= ST_OFF;
            slot_cnt      <= '0;
            blink_cnt     <= '0;
            faza          <= 1'b0;
            odswiezanie_o <= 2'b00;
            wygas_o       <= 1'b1;
            kropka_o      <= 1'b1;
        end else begin
            stan          <= stan_nx;
            slot_cnt      <= slot_cnt_nx;
            blink_cnt     <= blink_cnt_nx;
            faza          <= faza_nx;
            odswiezanie_o <= sel_nx;
            wygas_o       <= wygas_nx;
            kropka_o      <= kropka_nx;
        end
    end

    // Blink phase: a second-sync pulse wins over a coincident terminal count.
    always_comb begin
        blink_cnt_nx = '0;
        faza_nx      = 1'b0;
        if (en) begin
            if (sync_sek) begin
                blink_cnt_nx = '0;
                faza_nx      = 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nx = '0;
                faza_nx      = ~faza;
            end else begin
                blink_cnt_nx = blink_cnt + 1'b1;
                faza_nx      = faza;
            end
        end
    end

    always_comb begin
        stan_nx     = stan;
        slot_cnt_nx = slot_cnt;
        sel_nx      = odswiezanie_o;
        case (stan)
            ST_OFF: begin
                slot_cnt_nx = '0;
                sel_nx      = 2'b00;
                if (en) stan_nx = ST_BLANK;
            end
            ST_BLANK: begin
                slot_cnt_nx = slot_cnt + 1'b1;
                if (slot_cnt == GHOST_LAST) stan_nx = ST_SHOW;
            end
            ST_SHOW: begin
                if (slot_cnt == SLOT_LAST) begin
                    slot_cnt_nx = '0;
                    sel_nx      = odswiezanie_o + 2'd1;
                    stan_nx     = ST_BLANK;
                end else begin
                    slot_cnt_nx = slot_cnt + 1'b1;
                end
            end
            default: begin
                stan_nx     = ST_OFF;
                slot_cnt_nx = '0;
                sel_nx      = 2'b00;
            end
        endcase

        if (!en) begin
            stan_nx     = ST_OFF;
            slot_cnt_nx = '0;
            sel_nx      = 2'b00;
        end

        // Outputs are registered from next-state values so they line up
        // with the select/phase they describe.
        edit_blank = ~faza_nx &
                     (((tryb_ustaw == 2'b01) & ~sel_nx[1]) |
                      ((tryb_ustaw == 2'b10) &  sel_nx[1]));
        wygas_nx   = (stan_nx != ST_SHOW) | edit_blank;
        kropka_nx  = ~faza_nx;
    end

endmodule

// File: tb/tb_sterownik_skanowania.sv
// Scoreboard bench for sterownik_skanowania: stimulus pushes expected outputs
// per clock, a monitor pops and compares them after each rising edge.
module tb_sterownik_skanowania;

    localparam int SCAN_DIV  = 8;
    localparam int GHOST_CYC = 2;
    localparam int BLINK_DIV = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] tryb_ustaw = 2'b00;
    logic       sync_sek = 1'b0;
    logic [1:0] odswiezanie_o;
    logic       wygas_o;
    logic       kropka_o;

    always #5 clk = ~clk;

    sterownik_skanowania #(
        .SCAN_DIV (SCAN_DIV),
        .GHOST_CYC(GHOST_CYC),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .tryb_ustaw   (tryb_ustaw),
        .sync_sek     (sync_sek),
        .odswiezanie_o(odswiezanie_o),
        .wygas_o      (wygas_o),
        .kropka_o     (kropka_o)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic        wyg;
        logic        kro;
        logic [15:0] n;
        logic [7:0]  ph;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_cur = 0;
    int   last_sync = 0;
    int   phase = 0;

    // Closed-form expectation: nn = clocks since enable from a cleared state,
    // ls = clock index of the most recent second-sync (0 = none).
    function automatic exp_t model(input int nn, input int ls, input logic [1:0] tr);
        exp_t r;
        int   p;
        logic fz;
        r = '0;
        if (nn == 0) begin
            r.sel = 2'b00;
            r.wyg = 1'b1;
            r.kro = 1'b1;
        end else begin
            p     = nn - 1;
            r.sel = 2'((p / SCAN_DIV) % 4);
            if (ls != 0) fz = 1'b1 ^ 1'(((nn - ls) / BLINK_DIV) % 2);
            else         fz = 1'((nn / BLINK_DIV) % 2);
            r.wyg = ((p % SCAN_DIV) < GHOST_CYC);
            if (!fz && (((tr == 2'b01) && !r.sel[1]) || ((tr == 2'b10) && r.sel[1])))
                r.wyg = 1'b1;
            r.kro = ~fz;
        end
        r.n  = 16'(nn);
        r.ph = 8'(phase);
        return r;
    endfunction

    task automatic check_out(input string nm, input exp_t x);
        checks++;
        if (odswiezanie_o !== x.sel || wygas_o !== x.wyg || kropka_o !== x.kro) begin
            errors++;
            $display("FAIL %s ph=%0d n=%0d: got sel=%b wyg=%b kro=%b, want sel=%b wyg=%b kro=%b",
                     nm, x.ph, x.n, odswiezanie_o, wygas_o, kropka_o, x.sel, x.wyg, x.kro);
        end
    endtask

    // Called at a falling edge: drive, push expectation, advance one clock.
    task automatic step(input logic e, input logic [1:0] tr, input logic s);
        en         = e;
        tryb_ustaw = tr;
        sync_sek   = s;
        if (!e) begin
            n_cur     = 0;
            last_sync = 0;
        end else begin
            n_cur++;
            if (s) last_sync = n_cur;
        end
        q.push_back(model(n_cur, last_sync, tr));
        @(negedge clk);
    endtask

    task automatic run(input int cnt, input logic [1:0] tr);
        for (int i = 0; i < cnt; i++) step(1'b1, tr, 1'b0);
    endtask

    task automatic do_reset();
        exp_t r;
        rst_n     = 1'b0;
        en        = 1'b0;
        sync_sek  = 1'b0;
        n_cur     = 0;
        last_sync = 0;
        phase++;
        @(negedge clk);
        r = model(0, 0, 2'b00);
        check_out("reset", r);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check_out("scan", x);
            end
        end
    end

    initial begin : stimulus
        exp_t r;
        @(negedge clk);

        do_reset();
        run(60, 2'b00);

        do_reset();
        for (int i = 1; i <= 60; i++) step(1'b1, 2'b00, (i == 13) || (i == 33));

        do_reset();
        run(80, 2'b01);

        do_reset();
        run(80, 2'b10);

        do_reset();
        run(40, 2'b11);

        do_reset();
        run(20, 2'b00);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0);
        run(20, 2'b00);

        do_reset();
        run(12, 2'b00);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        r = model(0, 0, 2'b00);
        check_out("async_rst", r);
        n_cur     = 0;
        last_sync = 0;
        @(negedge clk);
        r = model(0, 0, 2'b00);
        check_out("rst_hold", r);
        @(negedge clk);
        rst_n = 1'b1;
        run(20, 2'b00);

        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sterownik_skanowania.md
Name: sterownik_skanowania

Overview:
- Sequences the 4-digit multiplexed HH:MM 7-segment display of the real-time clock.
- Generates the 2-bit digit-select (refresh) code consumed by the display decoder.
- Inserts an anti-ghosting blank window at each digit change and produces the blinking separator dot.
- Blanks the hour or minute digit pair at the blink rate while the user is setting the time. Sits between the clock core and the display decoder.

Parameters:
SCAN_DIV, 50000, clocks per digit slot (100 MHz -> 2 kHz slot rate, 500 Hz per digit); must be >= 2
GHOST_CYC, 1000, clocks at the start of each slot during which the digit is blanked; must be 1 .. SCAN_DIV-1
BLINK_DIV, 50000000, clocks per blink half-period (0.5 s at 100 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  display enable; 0 = display dark, all counters held cleared
tryb_ustaw  input  2  edit mode: 00 none, 01 hours being set, 10 minutes being set, 11 treated as 00
sync_sek  input  1  one-clock pulse from clock core at each new second; realigns blink phase
odswiezanie_o  output  2  digit select: 00 hour tens, 01 hour units, 10 minute tens, 11 minute units
wygas_o  output  1  1 = force current digit off (gates anode enable)
kropka_o  output  1  separator dot, active-low (0 = lit)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - FSM in OFF; slot counter, blink counter and faza all 0.
  - odswiezanie_o=00, wygas_o=1, kropka_o=1. All outputs are registered.
- FSM states are OFF, BLANK and SHOW.
  - OFF: wygas_o=1, kropka_o=1, odswiezanie_o=00, counters cleared. If en=1, next state is BLANK with slot counter 0.
  - BLANK: wygas_o=1. The slot counter increments each clock. When it reaches GHOST_CYC-1, next state is SHOW.
  - SHOW: wygas_o = edit-blank (see below). The slot counter increments. When it reaches SCAN_DIV-1, the counter is cleared, odswiezanie_o increments (wraps 11 -> 00), and next state is BLANK.
  - en=0 in any state: next clock goes to OFF and clears everything, including faza. A partial slot is discarded, not resumed.
- Slot timing:
  - Each digit is selected for exactly SCAN_DIV clocks.
  - Of those, the first GHOST_CYC clocks have wygas_o=1.
  - odswiezanie_o changes on the same edge wygas_o rises, so the select never changes while a digit is shown.
- Blink phase faza:
  - The blink counter runs while en=1. At BLINK_DIV-1 it clears and faza toggles.
  - A sync_sek pulse clears the blink counter and sets faza=1 on the next clock. It has priority over a coincident terminal count.
  - sync_sek is ignored while en=0.
- Dot: kropka_o = ~faza while en=1 (lit during faza=1). The dot is independent of the slot FSM and of edit mode.
- Edit blanking:
  - Applies in SHOW only when faza=0.
  - tryb_ustaw=01 forces wygas_o=1 for odswiezanie_o 00/01.
  - tryb_ustaw=10 forces wygas_o=1 for odswiezanie_o 10/11.
  - tryb_ustaw changes take effect on the next clock. No slot restart.
- Latency: en rising -> first SHOW after GHOST_CYC+1 clocks. Full refresh cycle = 4*SCAN_DIV clocks.
- Widths: counters sized with $clog2 of their divisor. No arithmetic overflow; both counters wrap only via the explicit clears.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock.

Test Plan:
Bench parameters: SCAN_DIV=8, GHOST_CYC=2, BLINK_DIV=20.
- Reset release with en=1, tryb=00 -> odswiezanie_o 00 for 8 clocks with wygas_o=1 on first 2 then 0 on 6; sequence 00,01,10,11,00 at 8-clock spacing; wygas_o rises on every select change.
- Free-run 60 clocks, no sync -> kropka_o toggles every 20 clocks, starting high (faza=0) after reset.
- sync_sek pulse at clock 13, with an extra pulse coincident with blink terminal count -> kropka_o=0 on next clock, next toggle exactly 20 clocks later; in the coincident case faza=1, not toggled to 0.
- tryb_ustaw=01 -> during faza=0, wygas_o=1 for whole slots 00/01 and normal for 10/11; during faza=1 all digits normal. Repeat with tryb_ustaw=10 for the minute digits, and tryb_ustaw=11 -> identical to 00.
- en dropped mid-SHOW of digit 10 -> next clock odswiezanie_o=00, wygas_o=1, kropka_o=1; en re-raised -> full 2-clock blank then digit 00.
- rst_n asserted asynchronously between clock edges mid-slot -> outputs at reset values before the next edge; normal sequence restarts after release.
